dsp_demux_acc: RTL and testbench

DSP_DEMUX_ACC -- requirements
Module: dsp_demux_acc

---
 rtl/dsp_demux_acc_if.sv | 39 +++
 rtl/dsp_demux_acc.sv | 164 ++++++++++++++++
 tb/tb_dsp_demux_acc.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/dsp_demux_acc_if.sv
// dsp_demux_acc_if -- bundle of the product input, the sample output and the
// status signals of dsp_demux_acc.
//
// Handshake semantics: the product side is a strobe only (din_en cannot be
// stalled, din_ready is purely advisory); a sample on the output side moves
// on a rising clk edge where dout_valid and dout_ready are both high, and
// dout_data/dout_lane hold steady while dout_valid is high and dout_ready
// is low.
//
// Signals:
//   din_en / din_ab / din_db    product pair from the packed INT8 multiplier
//   din_ready                   at least one pair slot free (or freed this cycle)
//   dout_valid / dout_ready     output sample handshake
//   dout_data / dout_lane       INT8 result and its lane (0 = A, 1 = D)
//   ovf                         sticky: a completed pair was dropped
//   state_dbg                   output FSM state (0 IDLE, 1 LANE_A, 2 LANE_D)
// Modports: slave = the accumulator block, master = whatever feeds and drains it.
interface dsp_demux_acc_if;
  logic               din_en;
  logic signed [15:0] din_ab;
  logic signed [15:0] din_db;
  logic               din_ready;
  logic               dout_valid;
  logic               dout_ready;
  logic        [7:0]  dout_data;
  logic               dout_lane;
  logic               ovf;
  logic        [1:0]  state_dbg;

  modport slave (
    input  din_en, din_ab, din_db, dout_ready,
    output din_ready, dout_valid, dout_data, dout_lane, ovf, state_dbg
  );

  modport master (
    output din_en, din_ab, din_db, dout_ready,
    input  din_ready, dout_valid, dout_data, dout_lane, ovf, state_dbg
  );
endinterface

// File: rtl/dsp_demux_acc.sv
// dsp_demux_acc -- accumulates TAPS dual products (lanes A and D) from a
// packed INT8 multiplier, shifts each completed sum right by SHIFT, reduces
// it to INT8 and queues the pair in a 2-entry buffer. An output FSM then
// serialises every pair as two samples: lane A first, then lane D.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    dsp_demux_acc_if.slave (product input, sample output, ovf, state)
//
// Build option: define DSP_DEMUX_ROUND_EN to round half up before the shift
// and saturate to [-128,127]; otherwise the shift floors and the low byte
// wraps.
module dsp_demux_acc #(
  parameter int TAPS  = 4,
  parameter int ACC_W = 20,
  parameter int SHIFT = 2
) (
  input logic            clk,
  input logic            rst_n,
  dsp_demux_acc_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LANE_A = 2'd1,
    LANE_D = 2'd2
  } state_t;

  localparam int CNT_W = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(TAPS - 1);

`ifdef DSP_DEMUX_ROUND_EN
  // 2^(SHIFT-1), or zero when SHIFT is zero.
  localparam logic [ACC_W:0] RND = ((ACC_W+1)'(1) << SHIFT) >> 1;

  function automatic logic [7:0] post_proc(input logic signed [ACC_W-1:0] s);
    logic signed [ACC_W:0] t;
    // One guard bit so the rounding addend can never overflow.
    t = $signed({s[ACC_W-1], s} + RND) >>> SHIFT;
    if ((t[ACC_W:7] == '0) || (t[ACC_W:7] == '1)) begin
      return t[7:0];
    end else if (t[ACC_W]) begin
      return 8'h80;
    end else begin
      return 8'h7f;
    end
  endfunction
`else
  function automatic logic [7:0] post_proc(input logic signed [ACC_W-1:0] s);
    return 8'(s >>> SHIFT);
  endfunction
`endif

  logic signed [ACC_W-1:0] acc_a, acc_d;
  logic signed [ACC_W-1:0] sum_a, sum_d;
  logic        [CNT_W-1:0] tap_cnt;
  logic                    last_tap;

  logic [7:0] mem_a [2];
  logic [7:0] mem_d [2];
  logic       wr_ptr, rd_ptr;
  logic [1:0] count, count_next;
  logic       pop, wr_ok, drop;
  logic       ovf_q;

  state_t state, state_next;

  assign sum_a    = acc_a + {{(ACC_W-16){bus.din_ab[15]}}, bus.din_ab};
  assign sum_d    = acc_d + {{(ACC_W-16){bus.din_db[15]}}, bus.din_db};
  assign last_tap = bus.din_en && (tap_cnt == LAST_TAP);

  // A pair leaves on the lane D handshake; that pop can make room for a
  // completion landing in the same cycle.
  assign pop        = (state == LANE_D) && bus.dout_ready;
  assign wr_ok      = last_tap && ((count != 2'd2) || pop);
  assign drop       = last_tap && (count == 2'd2) && !pop;
  assign count_next = count + {1'b0, wr_ok} - {1'b0, pop};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_a   <= '0;
      acc_d   <= '0;
      tap_cnt <= '0;
    end else if (bus.din_en) begin
      if (last_tap) begin
        acc_a   <= '0;
        acc_d   <= '0;
        tap_cnt <= '0;
      end else begin
        acc_a   <= sum_a;
        acc_d   <= sum_d;
        tap_cnt <= tap_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_a[0] <= '0;
      mem_a[1] <= '0;
      mem_d[0] <= '0;
      mem_d[1] <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_ok) begin
        mem_a[wr_ptr] <= post_proc(sum_a);
        mem_d[wr_ptr] <= post_proc(sum_d);
        wr_ptr        <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count_next;
      if (drop) begin
        ovf_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Looking at count_next lets IDLE leave in the same edge as the write.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (count_next != 2'd0) state_next = LANE_A;
      end
      LANE_A: begin
        if (bus.dout_ready) state_next = LANE_D;
      end
      LANE_D: begin
        if (bus.dout_ready) state_next = (count_next != 2'd0) ? LANE_A : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.dout_data = 8'h00;
    case (state)
      LANE_A:  bus.dout_data = mem_a[rd_ptr];
      LANE_D:  bus.dout_data = mem_d[rd_ptr];
      default: bus.dout_data = 8'h00;
    endcase
  end

  assign bus.dout_valid = (state == LANE_A) || (state == LANE_D);
  assign bus.dout_lane  = (state == LANE_D);
  assign bus.din_ready  = (count != 2'd2) || pop;
  assign bus.ovf        = ovf_q;
  assign bus.state_dbg  = state;

endmodule

// File: tb/tb_dsp_demux_acc.sv
// tb_dsp_demux_acc -- directed bench for dsp_demux_acc (TAPS=4, ACC_W=20,
// SHIFT=2). Expected samples are hand-computed and queued as {lane, byte};
// a monitor pops one entry per output handshake.
module tb_dsp_demux_acc;

  logic clk;
  logic rst_n;

  dsp_demux_acc_if bus ();

  dsp_demux_acc #(
    .TAPS (4),
    .ACC_W(20),
    .SHIFT(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [8:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, queue=%0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] smp(input logic lane, input int value);
    return {lane, 8'(value)};
  endfunction

  task automatic expect_pair(input int a, input int d);
    exp_q.push_back(smp(1'b0, a));
    exp_q.push_back(smp(1'b1, d));
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n && bus.dout_valid && bus.dout_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_sample", {23'd0, bus.dout_lane, bus.dout_data}, 32'h1ff);
      end else begin
        check("sample", {23'd0, bus.dout_lane, bus.dout_data}, {23'd0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic send_tap(input int ab, input int db);
    bus.din_en = 1'b1;
    bus.din_ab = 16'(ab);
    bus.din_db = 16'(db);
    @(posedge clk);
    #1;
    bus.din_en = 1'b0;
  endtask

  task automatic send_group(input int ab, input int db);
    repeat (4) send_tap(ab, db);
  endtask

  task automatic drain(input string tag);
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check(tag, exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n          = 1'b0;
    bus.din_en     = 1'b0;
    bus.din_ab     = '0;
    bus.din_db     = '0;
    bus.dout_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", bus.dout_valid, 0);
    check("rst_data", bus.dout_data, 0);
    check("rst_lane", bus.dout_lane, 0);
    check("rst_ovf", bus.ovf, 0);
    check("rst_din_ready", bus.din_ready, 1);
    check("rst_state", bus.state_dbg, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic pair and latency.
    bus.dout_ready = 1'b1;
    expect_pair(100, -3);
    repeat (3) send_tap(100, -3);
    check("lat_valid_before", bus.dout_valid, 0);
    send_tap(100, -3);
    check("lat_valid_after", bus.dout_valid, 1);
    check("lat_lane", bus.dout_lane, 0);
    check("lat_data", bus.dout_data, 32'(8'(100)));
    drain("drain_basic");

    // Rounding versus floor.
`ifdef DSP_DEMUX_ROUND_EN
    expect_pair(3, 0);
`else
    expect_pair(2, 0);
`endif
    send_tap(2, 0);
    send_tap(3, 0);
    send_tap(2, 0);
    send_tap(3, 0);
    drain("drain_round");

    // Saturation versus wrap.
`ifdef DSP_DEMUX_ROUND_EN
    expect_pair(127, -128);
`else
    expect_pair(-24, 24);
`endif
    send_group(1000, -1000);
    drain("drain_sat");

    // Held output, buffer full, third pair dropped.
    bus.dout_ready = 1'b0;
    expect_pair(4, 8);
    expect_pair(12, -4);
    send_group(4, 8);
    send_group(12, -4);
    check("full_din_ready", bus.din_ready, 0);
    check("full_ovf", bus.ovf, 0);
    send_group(40, 40);
    check("drop_ovf", bus.ovf, 1);
    check("drop_din_ready", bus.din_ready, 0);
    check("hold_valid", bus.dout_valid, 1);
    check("hold_lane", bus.dout_lane, 0);
    check("hold_data", bus.dout_data, 4);
    bus.dout_ready = 1'b1;
    drain("drain_drop");
    check("after_drop_ovf", bus.ovf, 1);
    check("after_drop_din_ready", bus.din_ready, 1);
    check("after_drop_valid", bus.dout_valid, 0);

    // Reset in the middle of a group.
    send_tap(50, 50);
    send_tap(50, 50);
    rst_n = 1'b0;
    #1;
    check("midrst_ovf", bus.ovf, 0);
    check("midrst_din_ready", bus.din_ready, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    expect_pair(8, 0);
    send_group(8, 0);
    drain("drain_midrst");

    // Completion with the buffer full and a lane D pop in the same edge.
    bus.dout_ready = 1'b0;
    expect_pair(16, -16);
    expect_pair(33, -33);
    expect_pair(-7, 7);
    send_group(16, -16);
    send_group(33, -33);
    send_tap(-7, 7);
    send_tap(-7, 7);
    bus.dout_ready = 1'b1;
    send_tap(-7, 7);
    check("pop_state_lane_d", bus.state_dbg, 2);
    bus.din_en = 1'b1;
    bus.din_ab = 16'(-7);
    bus.din_db = 16'(7);
    #1;
    check("pop_din_ready", bus.din_ready, 1);
    @(posedge clk);
    #1;
    bus.din_en = 1'b0;
    check("pop_no_ovf", bus.ovf, 0);
    check("pop_full_again", bus.din_ready, 0);
    drain("drain_pop");
    check("pop_final_ovf", bus.ovf, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
